// File: rtl/iv_fifo_port_if.sv
`default_nettype none
// ============================================================================
// Interface : iv_fifo_port_if
// Brief     : IV-bus strobes (SC, WC, LB, RB) plus the TX/RX byte streams of
//             the 8X305 FIFO port. The tri-state IV data pins stay a plain
//             module port because they need a resolved net.
// Revision  : 1.0 - initial release
// ============================================================================
interface iv_fifo_port_if;
  // IV bus control strobes
  logic       sc;
  logic       wc;
  logic       lb;
  logic       rb;
  // TX stream (peripheral -> system)
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  // RX stream (system -> peripheral)
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // Peripheral side
  modport slave (
    input  sc, wc, lb, rb,
    input  tx_ready, rx_data, rx_valid,
    output tx_data, tx_valid, rx_ready
  );

  // Core / system side
  modport master (
    output sc, wc, lb, rb,
    output tx_ready, rx_data, rx_valid,
    input  tx_data, tx_valid, rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/iv_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : iv_fifo_port
// Brief    : 8X305 IV-bus peripheral with 4 scratch registers, a TX FIFO push
//            port, an RX FIFO pop port, sticky status and a loopback control,
//            bridging the CPU to valid/ready byte streams.
// Revision : 1.0 - initial release
// ============================================================================
module iv_fifo_port #(
  parameter int unsigned BANK  = 0,      // 0 = left bank (LB), 1 = right bank (RB)
  parameter logic [7:0]  BASE  = 8'h20,  // address of register 0, low 3 bits zero
  parameter int unsigned DEPTH = 4       // entries per FIFO, power of two 2..16
) (
  input  wire       clk,
  input  wire       reset,               // synchronous, active-low
  inout  wire [7:0] iv,                  // active-low, bit-reversed IV pins
  iv_fifo_port_if.slave bus
);

  localparam bit             USE_RB   = (BANK != 0);
  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam int unsigned    CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [2:0]     REG_TXD  = 3'd4;
  localparam logic [2:0]     REG_RXD  = 3'd5;
  localparam logic [2:0]     REG_STAT = 3'd6;
  localparam logic [2:0]     REG_CTRL = 3'd7;

  // Pin <-> logical byte mapping: invert and reverse bit order. The mapping
  // is its own inverse, so one function serves both directions.
  function automatic logic [7:0] swz(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = ~v[7-b];
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7:0]    addr_q, addr_d;
  logic          loop_q, loop_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_unf_q, rx_unf_d;
  logic [7:0]    scratch_q [4];

  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d;
  logic [AW-1:0] tx_rd_q, tx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d;
  logic [AW-1:0] rx_rd_q, rx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;

  // --------------------------------------------------------------------------
  // Bus cycle decode
  // --------------------------------------------------------------------------
  logic       bank_sel;
  logic       sel;
  logic       hit;
  logic [2:0] idx;
  logic [7:0] iv_log;
  logic       addr_cyc;
  logic       wr_cyc;
  logic       rd_cyc;

  // Exactly one bank line must be low; both low or both high is ignored.
  assign bank_sel = USE_RB ? ~bus.rb : ~bus.lb;
  assign sel      = bank_sel & (bus.lb ^ bus.rb);
  assign hit      = (addr_q[7:3] == BASE[7:3]);
  assign idx      = addr_q[2:0];
  assign iv_log   = swz(iv);

  assign addr_cyc = sel &  bus.sc & ~bus.wc;
  assign wr_cyc   = sel &  bus.wc & ~bus.sc & hit;
  assign rd_cyc   = sel & ~bus.sc & ~bus.wc & hit;

  // --------------------------------------------------------------------------
  // FIFO flags and transfer strobes
  // --------------------------------------------------------------------------
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head;
  logic       lb_xfer;
  logic       tx_push_req, tx_push, tx_pop, tx_ovf_evt;
  logic       rx_pop_req, rx_push, rx_pop, rx_unf_evt;
  logic [7:0] rx_push_data;
  logic       stat_rd;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_head  = tx_mem_q[tx_rd_q];
  assign rx_head  = rx_mem_q[rx_rd_q];

  // Loopback moves one byte per cycle from TX head into RX while possible.
  assign lb_xfer     = loop_q & ~tx_empty & ~rx_full;

  assign tx_pop      = loop_q ? lb_xfer : (~tx_empty & bus.tx_ready);
  assign tx_push_req = wr_cyc & (idx == REG_TXD);
  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // accepted when the head is leaving at the same time.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovf_evt  = tx_push_req & tx_full & ~tx_pop;

  assign rx_push      = loop_q ? lb_xfer : (bus.rx_valid & ~rx_full);
  assign rx_push_data = loop_q ? tx_head : bus.rx_data;
  assign rx_pop_req   = rd_cyc & (idx == REG_RXD);
  assign rx_pop       = rx_pop_req & ~rx_empty;
  assign rx_unf_evt   = rx_pop_req & rx_empty;

  assign stat_rd      = rd_cyc & (idx == REG_STAT);

  // --------------------------------------------------------------------------
  // Streaming side outputs
  // --------------------------------------------------------------------------
  assign bus.tx_valid = ~tx_empty & ~loop_q;
  assign bus.tx_data  = tx_empty ? 8'h00 : tx_head;
  assign bus.rx_ready = ~rx_full & ~loop_q;

  // --------------------------------------------------------------------------
  // Read data and IV pin drive
  // --------------------------------------------------------------------------
  logic [7:0] status;
  logic [7:0] rd_val;
  logic       drive_en;

  assign status = {2'b00, rx_unf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

  // Register read multiplexer.
  always_comb begin
    rd_val = 8'h00;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_val = scratch_q[idx[1:0]];
      REG_TXD:                rd_val = 8'h00;
      REG_RXD:                rd_val = rx_empty ? 8'h00 : rx_head;
      REG_STAT:               rd_val = status;
      REG_CTRL:               rd_val = {7'b0, loop_q};
      default:                rd_val = 8'h00;
    endcase
  end

  // Pins are released while reset is held, even in the middle of a cycle.
  assign drive_en = rd_cyc & reset;
  assign iv       = drive_en ? swz(rd_val) : 8'hzz;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Address latch, control, sticky flags and FIFO pointers/counters.
  always_comb begin
    addr_d   = addr_q;
    loop_d   = loop_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;

    if (addr_cyc) addr_d = iv_log;
    if (wr_cyc && (idx == REG_CTRL)) loop_d = iv_log[0];

    // A new event on the clearing edge keeps the flag set.
    tx_ovf_d = tx_ovf_evt | (tx_ovf_q & ~stat_rd);
    rx_unf_d = rx_unf_evt | (rx_unf_q & ~stat_rd);

    if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
    if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
    if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
    if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;

    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Control/status state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      loop_q   <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      addr_q   <= addr_d;
      loop_q   <= loop_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // Scratch registers 0-3, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) scratch_q[i] <= 8'h00;
    end else if (wr_cyc && !idx[2]) begin
      scratch_q[idx[1:0]] <= iv_log;
    end
  end

  // FIFO storage; contents are don't-care while the counters say empty.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= iv_log;
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_push_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_iv_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_iv_fifo_port
// Brief    : Directed self-checking bench for iv_fifo_port (BANK=0, BASE=8'h20,
//            DEPTH=4): decode, bank select, FIFOs, sticky status, loopback,
//            illegal strobe combinations and mid-cycle reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iv_fifo_port;

  logic       clk = 1'b0;
  logic       reset;
  wire  [7:0] iv;
  logic       tb_oe;
  logic [7:0] tb_pins;
  logic       sel_l, sel_r;
  int         n_vec = 0;
  int         n_err = 0;

  iv_fifo_port_if bus();

  assign iv = tb_oe ? tb_pins : 8'hzz;

  iv_fifo_port #(.BANK(0), .BASE(8'h20), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .iv    (iv),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Logical byte <-> IV pins (invert + bit reverse).
  function automatic logic [7:0] swz(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = ~v[7-b];
    return r;
  endfunction

  // Pin sample with undriven bits reading as 0.
  function automatic logic [7:0] pins_now();
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = (iv[b] === 1'b1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_off();
    bus.lb = 1'b1; bus.rb = 1'b1; bus.sc = 1'b0; bus.wc = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic do_addr(input logic [7:0] a);
    bus.lb = sel_l; bus.rb = sel_r; bus.sc = 1'b1; bus.wc = 1'b0;
    tb_oe = 1'b1; tb_pins = swz(a);
    tick(); bus_off();
  endtask

  task automatic do_wr(input logic [7:0] d);
    bus.lb = sel_l; bus.rb = sel_r; bus.sc = 1'b0; bus.wc = 1'b1;
    tb_oe = 1'b1; tb_pins = swz(d);
    tick(); bus_off();
  endtask

  task automatic do_rd(output logic [7:0] p);
    bus.lb = sel_l; bus.rb = sel_r; bus.sc = 1'b0; bus.wc = 1'b0; tb_oe = 1'b0;
    #2 p = pins_now();
    tick(); bus_off();
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    do_addr(a); do_wr(d);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
    logic [7:0] p;
    do_addr(a); do_rd(p); v = swz(p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, p;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [4];
    exp1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp2 = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};

    reset = 1'b0; bus_off(); tb_pins = 8'h00;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    sel_l = 1'b0; sel_r = 1'b1;
    repeat (3) tick();
    reset = 1'b1;

    // Reset state
    check("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("rst_tx_data",  bus.tx_data,           8'h00);
    check("rst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    rd_reg(8'h26, v); check("rst_status", v, 8'h05);

    // Scratch write/read and bank selection
    wr_reg(8'h22, 8'hAC);
    do_addr(8'h22); do_rd(p); check("scr2_pins", p, 8'hCA);
    sel_l = 1'b1; sel_r = 1'b0;
    do_addr(8'h21); do_wr(8'h55); do_rd(p); check("opp_bank_hiz", p, 8'h00);
    sel_l = 1'b0; sel_r = 1'b1;
    do_rd(p); check("opp_bank_keep", swz(p), 8'hAC);
    rd_reg(8'h21, v); check("opp_bank_nowr", v, 8'h00);

    // TX fill with overflow, then drain
    do_addr(8'h24);
    do_wr(8'h11); do_wr(8'h22); do_wr(8'h33); do_wr(8'h44); do_wr(8'h55);
    check("tx_valid_full", {7'b0, bus.tx_valid}, 8'h01);
    check("tx_head",       bus.tx_data,          8'h11);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 check("tx_drain", bus.tx_data, exp1[i]);
      tick();
    end
    bus.tx_ready = 1'b0;
    check("tx_valid_empty", {7'b0, bus.tx_valid}, 8'h00);
    rd_reg(8'h26, v); check("stat_ovf",     v, 8'h15);
    rd_reg(8'h26, v); check("stat_ovf_clr", v, 8'h05);

    // RX stream in, pops, underflow
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    #2 check("rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    tick();
    bus.rx_data = 8'hA5; tick();
    bus.rx_valid = 1'b0;
    do_addr(8'h25);
    do_rd(p); check("rx_pop0", swz(p), 8'h5A);
    do_rd(p); check("rx_pop1", swz(p), 8'hA5);
    do_rd(p); check("rx_unf_rd", swz(p), 8'h00);
    rd_reg(8'h26, v); check("stat_unf",     v, 8'h25);
    rd_reg(8'h26, v); check("stat_unf_clr", v, 8'h05);

    // Loopback
    wr_reg(8'h27, 8'h01);
    rd_reg(8'h27, v); check("ctrl_rd", v, 8'h01);
    wr_reg(8'h24, 8'h3C);
    check("lb_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("lb_rx_ready", {7'b0, bus.rx_ready}, 8'h00);
    do_addr(8'h25); do_rd(p); check("lb_rx_data", swz(p), 8'h3C);
    rd_reg(8'h26, v); check("lb_status", v, 8'h05);
    wr_reg(8'h27, 8'h00);

    // Push and pop on the same edge while TX is full
    do_addr(8'h24);
    do_wr(8'hA1); do_wr(8'hA2); do_wr(8'hA3); do_wr(8'hA4);
    rd_reg(8'h26, v); check("full_status", v, 8'h06);
    do_addr(8'h24);
    bus.tx_ready = 1'b1; do_wr(8'hA5); bus.tx_ready = 1'b0;
    rd_reg(8'h26, v); check("pushpop_status", v, 8'h06);
    check("pushpop_head", bus.tx_data, 8'hA2);
    do_addr(8'h24); do_wr(8'hA6);
    rd_reg(8'h26, v); check("full_ovf_status", v, 8'h16);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 check("pushpop_drain", bus.tx_data, exp2[i]);
      tick();
    end
    bus.tx_ready = 1'b0;
    check("pushpop_empty", {7'b0, bus.tx_valid}, 8'h00);

    // Illegal strobe combinations leave state alone and never drive
    wr_reg(8'h21, 8'h5E);
    bus.lb = 1'b0; bus.rb = 1'b0; bus.sc = 1'b1; bus.wc = 1'b1;
    tb_oe = 1'b1; tb_pins = swz(8'h22); tick();
    bus.lb = 1'b0; bus.rb = 1'b0; bus.sc = 1'b1; bus.wc = 1'b0;
    tb_pins = swz(8'h22); tick();
    bus.lb = 1'b0; bus.rb = 1'b0; bus.sc = 1'b0; bus.wc = 1'b1;
    tb_pins = swz(8'h77); tick();
    bus.lb = 1'b0; bus.rb = 1'b0; bus.sc = 1'b0; bus.wc = 1'b0; tb_oe = 1'b0;
    #2 check("both_banks_hiz", pins_now(), 8'h00);
    tick();
    bus.lb = sel_l; bus.rb = sel_r; bus.sc = 1'b1; bus.wc = 1'b1;
    tb_oe = 1'b1; tb_pins = swz(8'h77); tick();
    tb_oe = 1'b0;
    #2 check("scwc_hiz", pins_now(), 8'h00);
    tick();
    bus_off();
    do_rd(p); check("addr_kept", swz(p), 8'h5E);
    rd_reg(8'h22, v); check("scr2_kept", v, 8'hAC);

    // Reset in the middle of a read cycle with both FIFOs part full
    do_addr(8'h24); do_wr(8'h01); do_wr(8'h02);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h61; tick();
    bus.rx_data = 8'h62; tick();
    bus.rx_valid = 1'b0;
    check("mid_tx_valid", {7'b0, bus.tx_valid}, 8'h01);
    do_addr(8'h26);
    bus.lb = sel_l; bus.rb = sel_r; bus.sc = 1'b0; bus.wc = 1'b0; tb_oe = 1'b0;
    #2 check("mid_status", swz(pins_now()), 8'h00);
    reset = 1'b0;
    #1 check("rst_mid_hiz", pins_now(), 8'h00);
    tick();
    reset = 1'b1; bus_off();
    check("rst2_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("rst2_tx_data",  bus.tx_data,           8'h00);
    check("rst2_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    rd_reg(8'h26, v); check("rst2_status",  v, 8'h05);
    rd_reg(8'h22, v); check("rst2_scratch", v, 8'h00);
    rd_reg(8'h27, v); check("rst2_ctrl",    v, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
